// File: rtl/am_demod_pkg.sv
// am_demod_pkg: shared FSM state type and datapath widths for the AM magnitude engine
package am_demod_pkg;
  localparam int AM_WIDTH = 12;
  localparam int SUM_W = 2*AM_WIDTH;
  localparam int REM_W = AM_WIDTH+2;
  localparam int CNT_W = $clog2(AM_WIDTH);
  typedef enum logic [2:0] {IDLE, MUL_I, MUL_Q, SQRT, DONE} state_t;
endpackage

// File: rtl/am_sqrt_iter.sv
// am_sqrt_iter: one combinational restoring square-root step (rem, root, radicand pair) -> (rem', root')
module am_sqrt_iter import am_demod_pkg::*; #(
  parameter int W = AM_WIDTH,
  parameter int RW = REM_W
) (
  input  logic [RW-1:0] rem,
  input  logic [W-1:0]  root,
  input  logic [1:0]    pair,
  output logic [RW-1:0] rem_nxt,
  output logic [W-1:0]  root_nxt
);
  logic [RW+1:0] acc, trial;
  logic ge;
  always_comb begin
    acc = {rem, pair};
    trial = {2'b00, root, 2'b01};
    ge = acc >= trial;
    rem_nxt = ge ? RW'(acc - trial) : RW'(acc);
    root_nxt = W'({root, ge});
  end
endmodule

// File: rtl/am_demod_tdm_ctrl.sv
// am_demod_tdm_ctrl: sequenced sqrt(I^2+Q^2) with one shared multiplier and a bit-serial root.
// Define AM_DEMOD_ROUND_EN to round the magnitude to nearest instead of truncating.
module am_demod_tdm_ctrl import am_demod_pkg::*; #(
  parameter int WIDTH = AM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I_in,
  input  logic [WIDTH-1:0] Q_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int SW = 2*WIDTH;
  localparam int RW = WIDTH+2;
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic signed [WIDTH-1:0] i_r, q_r;
  logic signed [SW-1:0] opx, prod;
  logic [SW-1:0] sum;
  logic [RW-1:0] rem, rem_nxt;
  logic [WIDTH-1:0] root, root_nxt, res;
  logic [CW-1:0] cnt;
  assign opx = SW'(state == MUL_Q ? q_r : i_r);
  assign prod = opx * opx;
  assign in_ready = state == IDLE;
  assign busy = !in_ready;
  am_sqrt_iter #(.W(WIDTH), .RW(RW)) u_iter (
    .rem(rem), .root(root), .pair(sum[SW-1 -: 2]), .rem_nxt(rem_nxt), .root_nxt(root_nxt)
  );
`ifdef AM_DEMOD_ROUND_EN
  assign res = (rem_nxt > {2'b00, root_nxt}) ? root_nxt + WIDTH'(1) : root_nxt;
`else
  assign res = root_nxt;
`endif
  always_comb begin
    nxt = state == IDLE  ? (in_valid ? MUL_I : IDLE) :
          state == MUL_I ? MUL_Q :
          state == MUL_Q ? SQRT :
          state == SQRT  ? (cnt == CW'(WIDTH-1) ? DONE : SQRT) :
          (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i_r <= '0;
      q_r <= '0;
      sum <= '0;
      rem <= '0;
      root <= '0;
      cnt <= '0;
      d_out <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        i_r <= I_in;
        q_r <= Q_in;
      end
      if (state == MUL_I) sum <= $unsigned(prod);
      if (state == MUL_Q) begin
        sum <= sum + $unsigned(prod);
        rem <= '0;
        root <= '0;
        cnt <= '0;
      end
      // radicand is consumed MSB pair first by shifting it up each iteration
      if (state == SQRT) begin
        sum <= sum << 2;
        rem <= rem_nxt;
        root <= root_nxt;
        cnt <= cnt + CW'(1);
        if (nxt == DONE) begin
          d_out <= res;
          out_valid <= 1'b1;
        end
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_am_demod_tdm_ctrl.sv
// tb_am_demod_tdm_ctrl: directed self-checking bench for am_demod_tdm_ctrl (honours AM_DEMOD_ROUND_EN)
module tb_am_demod_tdm_ctrl;
  localparam int W = 12;
`ifdef AM_DEMOD_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] I_in = '0, Q_in = '0, d_out;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  am_demod_tdm_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .I_in(I_in), .Q_in(Q_in), .in_valid(in_valid), .in_ready(in_ready),
    .d_out(d_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic start(input int i, input int q);
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    I_in = W'(i);
    Q_in = W'(q);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_out(input string tag);
    int n = 0;
    bit busy_ok = 1'b1;
    while (!out_valid && n < 40) begin
      busy_ok &= busy;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, W + 2);
    chk({tag, "_busy"}, int'(busy_ok), 1);
  endtask
  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_out_valid", int'(out_valid), 0);
    chk("drain_in_ready", int'(in_ready), 1);
  endtask
  task automatic run(input string tag, input int i, input int q, input int exp);
    start(i, q);
    wait_out(tag);
    chk(tag, int'(d_out), exp);
    drain();
  endtask
  initial begin
    #12;
    chk("rst_d_out", int'(d_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    run("i3q4", 3, 4, 5);
    run("max_neg", -2048, -2048, 2896);
    run("zero", 0, 0, 0);
    run("i2047", 2047, 0, 2047);
    run("i2q2", 2, 2, RND ? 3 : 2);
    run("i5q5", 5, 5, 7);
    run("i11q11", 11, 11, RND ? 16 : 15);
    run("neg1", -1, -1, 1);
    run("n7q24", -7, 24, 25);
    run("i100", 100, -100, 141);
    run("i1000", 1000, 1000, 1414);
    // back-pressure: result held, new input ignored while DONE
    start(30, 40);
    wait_out("stall");
    for (int k = 0; k < 20; k++) begin
      I_in = W'(k + 1);
      Q_in = W'(k + 2);
      in_valid = 1'b1;
      @(negedge clk);
      chk("stall_d_out", int'(d_out), 50);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    drain();
    chk("stall_busy_idle", int'(busy), 0);
    run("after_stall", 0, 7, 7);
    // async reset mid-SQRT, after a nonzero result is latched
    start(6, 8);
    repeat (6) @(negedge clk);
    chk("pre_rst_d_out", int'(d_out), 7);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_d_out", int'(d_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_no_out", int'(out_valid), 0);
    run("i6q8", 6, 8, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
